// File: rtl/sap_controller.sv
// SAP-1 control sequencer: one-hot T1..T6 ring with a HALT state, decoding the
// opcode nibble into the control word for the PC/MAR/RAM/IR/A/B/ALU/OUT blocks.
module sap_controller #(
  parameter logic [3:0] OP_LDA      = 4'b0000,
  parameter logic [3:0] OP_ADD      = 4'b0001,
  parameter logic [3:0] OP_SUB      = 4'b0010,
  parameter logic [3:0] OP_OUT      = 4'b1110,
  parameter logic [3:0] OP_HLT      = 4'b1111,
  parameter bit         SHORT_CYCLE = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] instruction,
  output logic       cp,
  output logic       ep,
  output logic       lm_n,
  output logic       ce_n,
  output logic       li_n,
  output logic       ei_n,
  output logic       la_n,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb_n,
  output logic       lo_n,
  output logic [5:0] t_state,
  output logic       halted
);

  // The state code is the visible one-hot T-state; HALT is the all-zero code.
  typedef enum logic [5:0] {
    ST_HALT = 6'b000000,
    ST_T1   = 6'b000001,
    ST_T2   = 6'b000010,
    ST_T3   = 6'b000100,
    ST_T4   = 6'b001000,
    ST_T5   = 6'b010000,
    ST_T6   = 6'b100000
  } state_t;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm_n;
    logic ce_n;
    logic li_n;
    logic ei_n;
    logic la_n;
    logic ea;
    logic su;
    logic eu;
    logic lb_n;
    logic lo_n;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{cp: 1'b0, ep: 1'b0, lm_n: 1'b1, ce_n: 1'b1,
                                  li_n: 1'b1, ei_n: 1'b1, la_n: 1'b1, ea: 1'b0,
                                  su: 1'b0, eu: 1'b0, lb_n: 1'b1, lo_n: 1'b1};

  state_t state;
  logic   halted_q;
  ctrl_t  ctrl;

  logic is_lda;
  logic is_add;
  logic is_sub;
  logic is_out;
  logic is_hlt;
  logic is_undef;
  logic end_at_t4;
  logic end_at_t5;

  assign is_lda   = (instruction == OP_LDA);
  assign is_add   = (instruction == OP_ADD);
  assign is_sub   = (instruction == OP_SUB);
  assign is_out   = (instruction == OP_OUT);
  assign is_hlt   = (instruction == OP_HLT);
  assign is_undef = !(is_lda || is_add || is_sub || is_out || is_hlt);

  // Short machine cycles end as soon as every remaining T-state would be a NOP.
  always_comb begin
    end_at_t4 = 1'b0;
    end_at_t5 = 1'b0;
    if (SHORT_CYCLE) begin
      end_at_t4 = is_out || is_undef;
      end_at_t5 = !(is_add || is_sub);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_T1;
      halted_q <= 1'b0;
    end else begin
      case (state)
        ST_T1: state <= ST_T2;
        ST_T2: state <= ST_T3;
        ST_T3: state <= ST_T4;
        ST_T4: begin
          if (is_hlt) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else if (end_at_t4) begin
            state <= ST_T1;
          end else begin
            state <= ST_T5;
          end
        end
        ST_T5:   state <= end_at_t5 ? ST_T1 : ST_T6;
        ST_T6:   state <= ST_T1;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_T1;
      endcase
    end
  end

  // Decode is gated by reset so nothing drives the bus while reset is held.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (reset) begin
      case (state)
        ST_T1: begin
          ctrl.ep   = 1'b1;
          ctrl.lm_n = 1'b0;
        end
        ST_T2: ctrl.cp = 1'b1;
        ST_T3: begin
          ctrl.ce_n = 1'b0;
          ctrl.li_n = 1'b0;
        end
        ST_T4: begin
          if (is_lda || is_add || is_sub) begin
            ctrl.ei_n = 1'b0;
            ctrl.lm_n = 1'b0;
          end else if (is_out) begin
            ctrl.ea   = 1'b1;
            ctrl.lo_n = 1'b0;
          end
        end
        ST_T5: begin
          if (is_lda) begin
            ctrl.ce_n = 1'b0;
            ctrl.la_n = 1'b0;
          end else if (is_add || is_sub) begin
            ctrl.ce_n = 1'b0;
            ctrl.lb_n = 1'b0;
          end
        end
        ST_T6: begin
          if (is_add || is_sub) begin
            ctrl.eu   = 1'b1;
            ctrl.su   = is_sub;
            ctrl.la_n = 1'b0;
          end
        end
        default: ctrl = CTRL_IDLE;
      endcase
    end
  end

  assign cp      = ctrl.cp;
  assign ep      = ctrl.ep;
  assign lm_n    = ctrl.lm_n;
  assign ce_n    = ctrl.ce_n;
  assign li_n    = ctrl.li_n;
  assign ei_n    = ctrl.ei_n;
  assign la_n    = ctrl.la_n;
  assign ea      = ctrl.ea;
  assign su      = ctrl.su;
  assign eu      = ctrl.eu;
  assign lb_n    = ctrl.lb_n;
  assign lo_n    = ctrl.lo_n;
  assign t_state = state;
  assign halted  = halted_q;

endmodule

// File: tb/tb_sap_controller.sv
// Bench for sap_controller: a full-cycle and a short-cycle instance run side by
// side against a T-state/opcode table model with randomized opcode streams.
module tb_sap_controller;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // clock / reset
  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DUT signals, index 0 = SHORT_CYCLE 0, index 1 = SHORT_CYCLE 1
  logic [3:0] instr_w   [2];
  logic [5:0] t_state_w [2];
  logic [1:0] cp_w, ep_w, lm_n_w, ce_n_w, li_n_w, ei_n_w, la_n_w;
  logic [1:0] ea_w, su_w, eu_w, lb_n_w, lo_n_w, halted_w;

  sap_controller #(.SHORT_CYCLE(1'b0)) dut_long (
    .clock(clock), .reset(reset), .instruction(instr_w[0]),
    .cp(cp_w[0]), .ep(ep_w[0]), .lm_n(lm_n_w[0]), .ce_n(ce_n_w[0]),
    .li_n(li_n_w[0]), .ei_n(ei_n_w[0]), .la_n(la_n_w[0]), .ea(ea_w[0]),
    .su(su_w[0]), .eu(eu_w[0]), .lb_n(lb_n_w[0]), .lo_n(lo_n_w[0]),
    .t_state(t_state_w[0]), .halted(halted_w[0])
  );

  sap_controller #(.SHORT_CYCLE(1'b1)) dut_short (
    .clock(clock), .reset(reset), .instruction(instr_w[1]),
    .cp(cp_w[1]), .ep(ep_w[1]), .lm_n(lm_n_w[1]), .ce_n(ce_n_w[1]),
    .li_n(li_n_w[1]), .ei_n(ei_n_w[1]), .la_n(la_n_w[1]), .ea(ea_w[1]),
    .su(su_w[1]), .eu(eu_w[1]), .lb_n(lb_n_w[1]), .lo_n(lo_n_w[1]),
    .t_state(t_state_w[1]), .halted(halted_w[1])
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: current T-state number (1..6), halt flag, opcode of the cycle
  int         m_t    [2];
  bit         m_halt [2];
  logic [3:0] m_op   [2];
  logic [3:0] exp_q0 [$];
  logic [3:0] exp_q1 [$];

  function automatic logic [3:0] pick_op(int d);
    if (d == 0 && exp_q0.size() > 0) return exp_q0.pop_front();
    if (d == 1 && exp_q1.size() > 0) return exp_q1.pop_front();
    return 4'($urandom_range(0, 14));
  endfunction

  // clocks per machine cycle
  function automatic int cycle_len(logic [3:0] op, bit short_mode);
    if (!short_mode) return 6;
    if (op == OP_ADD || op == OP_SUB) return 6;
    if (op == OP_LDA) return 5;
    return 4;
  endfunction

  // Expected word ordered {cp,ep,lm_n,ce_n,li_n,ei_n,la_n,ea,su,eu,lb_n,lo_n}
  function automatic logic [11:0] exp_ctrl(int t, bit active, logic [3:0] op);
    logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
    bit   alu_op;
    cp = 0; ep = 0; lm_n = 1; ce_n = 1; li_n = 1; ei_n = 1;
    la_n = 1; ea = 0; su = 0; eu = 0; lb_n = 1; lo_n = 1;
    alu_op = (op == OP_ADD) || (op == OP_SUB);
    if (active) begin
      if (t == 1) begin ep = 1; lm_n = 0; end
      if (t == 2) cp = 1;
      if (t == 3) begin ce_n = 0; li_n = 0; end
      if (t == 4 && (op == OP_LDA || alu_op)) begin ei_n = 0; lm_n = 0; end
      if (t == 4 && op == OP_OUT) begin ea = 1; lo_n = 0; end
      if (t == 5 && op == OP_LDA) begin ce_n = 0; la_n = 0; end
      if (t == 5 && alu_op) begin ce_n = 0; lb_n = 0; end
      if (t == 6 && alu_op) begin eu = 1; su = (op == OP_SUB); la_n = 0; end
    end
    return {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n};
  endfunction

  function automatic logic [11:0] dut_ctrl(int d);
    return {cp_w[d], ep_w[d], lm_n_w[d], ce_n_w[d], li_n_w[d], ei_n_w[d],
            la_n_w[d], ea_w[d], su_w[d], eu_w[d], lb_n_w[d], lo_n_w[d]};
  endfunction

  function automatic int bus_drivers(int d);
    return int'(ep_w[d]) + int'(!ce_n_w[d]) + int'(!ei_n_w[d]) + int'(ea_w[d]) + int'(eu_w[d]);
  endfunction

  // driver tasks
  task automatic drive_inputs();
    for (int d = 0; d < 2; d++) begin
      if (m_halt[d] || m_t[d] <= 2) instr_w[d] = 4'($urandom_range(0, 15));
      else                          instr_w[d] = m_op[d];
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_t_state", d), 32'(t_state_w[d]),
            m_halt[d] ? 32'd0 : 32'(6'd1 << (m_t[d] - 1)));
      check($sformatf("d%0d_halted", d), 32'(halted_w[d]), 32'(m_halt[d]));
      check($sformatf("d%0d_ctrl_t%0d_op%0h", d, m_t[d], m_op[d]), 32'(dut_ctrl(d)),
            32'(exp_ctrl(m_t[d], !m_halt[d], m_op[d])));
      check($sformatf("d%0d_bus_excl", d), 32'(bus_drivers(d) <= 1), 32'd1);
    end
  endtask

  task automatic advance_models();
    for (int d = 0; d < 2; d++) begin
      if (!m_halt[d]) begin
        if (m_t[d] == 4 && m_op[d] == OP_HLT) begin
          m_halt[d] = 1'b1;
        end else if (m_t[d] >= cycle_len(m_op[d], d == 1)) begin
          m_t[d]  = 1;
          m_op[d] = pick_op(d);
        end else begin
          m_t[d]++;
        end
      end
    end
  endtask

  // One clock: drive after the edge, compare on the falling edge, advance on the rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      drive_inputs();
      @(negedge clock);
      compare_all();
      @(posedge clock);
      advance_models();
      #1;
    end
  endtask

  // Asserts reset mid-period; the first check lands before any clock edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_t_state", d), 32'(t_state_w[d]), 32'd1);
      check($sformatf("d%0d_rst_halted", d), 32'(halted_w[d]), 32'd0);
      check($sformatf("d%0d_rst_ctrl", d), 32'(dut_ctrl(d)), 32'(exp_ctrl(1, 1'b0, OP_LDA)));
    end
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_hold_t_state", d), 32'(t_state_w[d]), 32'd1);
      check($sformatf("d%0d_rst_hold_ctrl", d), 32'(dut_ctrl(d)), 32'(exp_ctrl(1, 1'b0, OP_LDA)));
    end
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_t[d]    = 1;
      m_halt[d] = 1'b0;
      m_op[d]   = pick_op(d);
    end
  endtask

  initial begin
    reset      = 1'b0;
    instr_w[0] = 4'h0;
    instr_w[1] = 4'h0;
    for (int d = 0; d < 2; d++) begin
      m_t[d] = 1; m_halt[d] = 1'b0; m_op[d] = OP_LDA;
    end
    @(posedge clock);
    #1;

    // directed opening cycles, then random opcode stream without HLT
    exp_q0 = '{OP_LDA, OP_ADD, OP_SUB, 4'h7, OP_OUT};
    exp_q1 = '{OP_OUT, OP_LDA, OP_ADD, OP_SUB, 4'h7};
    do_reset();
    step(250);

    // asynchronous reset in the middle of T5 of an ADD
    exp_q0.delete(); exp_q1.delete();
    exp_q0.push_back(OP_ADD);
    exp_q1.push_back(OP_ADD);
    do_reset();
    step(4);
    check("d0_mid_t5_model", 32'(m_t[0]), 32'd5);
    do_reset();
    step(30);

    // halt: both instances pick HLT at their next T1 and then stay put
    exp_q0.push_back(OP_HLT);
    exp_q1.push_back(OP_HLT);
    step(12);
    check("d0_halt_reached", 32'(m_halt[0]), 32'd1);
    check("d1_halt_reached", 32'(m_halt[1]), 32'd1);
    step(20);
    do_reset();
    step(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
- Control/sequencer unit for the 8-bit SAP-1 datapath (PC, MAR, RAM, instruction register, accumulator, B register, adder/subtractor, output register).
- Runs a one-hot ring counter through T1..T6 and decodes the instruction register's opcode nibble into the control word that drives each block's enable and load pins.
- Handles halt and undefined opcodes, and can optionally terminate a machine cycle early when the remaining T-states do nothing.

Parameters:
- OP_LDA, 4'b0000, opcode for load accumulator from memory.
- OP_ADD, 4'b0001, opcode for A <= A + B(mem).
- OP_SUB, 4'b0010, opcode for A <= A - B(mem).
- OP_OUT, 4'b1110, opcode for output register <= A.
- OP_HLT, 4'b1111, opcode for halt.
- SHORT_CYCLE, 0, 1 = return to T1 immediately after the last non-NOP T-state; 0 = always run all six T-states.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  4  opcode nibble from the instruction register (IR[7:4]).
- cp  out  1  PC increment, active-high.
- ep  out  1  PC drive bus, active-high.
- lm_n  out  1  MAR load, active-low.
- ce_n  out  1  RAM drive bus, active-low.
- li_n  out  1  IR load, active-low.
- ei_n  out  1  IR drive bus (low nibble), active-low.
- la_n  out  1  accumulator load, active-low.
- ea  out  1  accumulator drive bus, active-high.
- su  out  1  ALU mode (0 = add, 1 = sub).
- eu  out  1  ALU drive bus, active-high.
- lb_n  out  1  B register load, active-low.
- lo_n  out  1  output register load, active-low.
- t_state  out  6  one-hot current T-state; bit0 = T1.
- halted  out  1  high while in HALT.

Behaviour:
- State register: one-hot T1..T6 plus a HALT flag.
- Control outputs are combinational decode of (state, instruction). "Inactive" means cp=ep=ea=su=eu=0 and every _n signal = 1.
- While reset=0, asynchronously: t_state=6'b000001, halted=0, and all control outputs forced inactive regardless of state.
- After reset release, the T1 decode is active during the first clock period.
- Fetch cycle, same for every opcode:
  - T1: ep=1, lm_n=0.
  - T2: cp=1.
  - T3: ce_n=0, li_n=0.
- The opcode is sampled from `instruction` during T4..T6 only; its value in T1..T3 is ignored.
- LDA:
  - T4: ei_n=0, lm_n=0.
  - T5: ce_n=0, la_n=0.
  - T6: NOP.
- ADD:
  - T4: ei_n=0, lm_n=0.
  - T5: ce_n=0, lb_n=0.
  - T6: eu=1, su=0, la_n=0.
- SUB: same as ADD, except su=1 in T6 only.
- OUT:
  - T4: ea=1, lo_n=0.
  - T5, T6: NOP.
- HLT:
  - T4 decodes as inactive.
  - At the T4 rising edge: halted<=1, t_state<=6'b000000.
  - The block stays halted with all outputs inactive until reset is asserted; clock edges have no effect.
- Undefined opcode: T4..T6 are NOP; no halt.
- Transitions (SHORT_CYCLE=0): T1->T2->...->T6->T1, one state per clock.
- Machine-cycle length with SHORT_CYCLE=1:
  - OUT: T4->T1 (4 clocks).
  - LDA: T5->T1 (5 clocks).
  - ADD/SUB: 6 clocks.
  - Undefined opcode: T3->T4->T1 (4 clocks).
- At most one bit of t_state is ever set; none are set only when halted.
- The bus-drive enables ep, ce_n, ei_n, ea and eu are mutually exclusive in every state; verification asserts this.
- Reset asserted mid-cycle (any T-state or HALT) returns to T1 asynchronously; the in-flight instruction is abandoned.

Test Plan:
- Reset low, then release; instruction=4'h0 -> t_state sequence 01,02,04,08,10,20,01; T1 ep=1/lm_n=0; T2 cp=1; T3 ce_n=0/li_n=0.
- instruction=OP_ADD (4'h1) held from T3 -> T4 ei_n=0/lm_n=0; T5 ce_n=0/lb_n=0; T6 eu=1/su=0/la_n=0; back to T1 next clock.
- instruction=OP_SUB (4'h2) -> identical to ADD except su=1 only in T6; su=0 in all other states.
- instruction=OP_HLT (4'hF) at T4 -> next edge halted=1, t_state=0, outputs inactive for 20 further clocks; reset low then high -> halted=0, t_state=01.
- SHORT_CYCLE=1, OUT (4'hE) then LDA (4'h0) -> OUT completes in 4 clocks with T4 ea=1/lo_n=0; LDA completes in 5 clocks; t_state never reaches 20 for either.
- Reset pulsed low mid-T5 of ADD -> t_state=01 immediately (asynchronously), lb_n=1 during reset, normal fetch resumes after release; undefined opcode 4'h7 -> T4..T6 all outputs inactive.
